cache_controller_2way: RTL and testbench



---
 rtl/cache_controller_2way_if.sv | 36 +++
 rtl/cache_controller_2way.sv | 181 ++++++++++++++++++
 tb/tb_cache_controller_2way.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_2way_if.sv
// Bus interfaces for the 2-way data cache: the MEM-stage request port and the SRAM block port.
interface cache_cpu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              read_en;
  logic              write_en;
  logic              flush;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (output read_en, write_en, flush, address, write_data,
                  input  read_data, ready);
  modport slave  (input  read_en, write_en, flush, address, write_data,
                  output read_data, ready);
endinterface

interface cache_sram_if #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 2
);
  logic [ADDR_W-1:0]                 sram_address;
  logic [DATA_W-1:0]                 sram_write_data;
  logic                              sram_read_en;
  logic                              sram_write_en;
  logic [DATA_W*WORDS_PER_BLOCK-1:0] sram_read_data;
  logic                              sram_ready;

  modport master (output sram_address, sram_write_data, sram_read_en, sram_write_en,
                  input  sram_read_data, sram_ready);
  modport slave  (input  sram_address, sram_write_data, sram_read_en, sram_write_en,
                  output sram_read_data, sram_ready);
endinterface

// File: rtl/cache_controller_2way.sv
// 2-way set-associative write-through data cache with true LRU, flush and saturating hit/miss counters.
// state     | meaning
// IDLE      | combinational lookup; read hits complete here
// FLUSH     | clear all valid/LRU bits
// MEM_READ  | block read from SRAM outstanding
// FILL      | write fetched block into victim way
// DONE      | present fill word, ready for one cycle
// MEM_WRITE | word write-through outstanding
module cache_controller_2way #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int SETS            = 64,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_cpu_if.slave        cpu,
  cache_sram_if.master      mem,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int WOFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int WSEL_W  = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int IDX_W   = $clog2(SETS);
  localparam int IDX_LSB = 2 + WOFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [WSEL_W-1:0] WMASK = WSEL_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {IDLE, FLUSH, MEM_READ, FILL, DONE, MEM_WRITE} state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [DATA_W-1:0] data_q  [2][SETS][WORDS_PER_BLOCK];
  logic [DATA_W-1:0] fill_q  [WORDS_PER_BLOCK];
  logic [DATA_W-1:0] blk_in  [WORDS_PER_BLOCK];
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word;
  logic              hit0, hit1, hit, hit_way, victim, read_hit;
  logic              ready_c, clear_all, lru_we, lru_val, fill_we, wr_we, buf_we;
  logic [DATA_W-1:0] hit_word;

  assign idx      = cpu.address[IDX_LSB +: IDX_W];
  assign tag      = cpu.address[ADDR_W-1:TAG_LSB];
  assign word     = cpu.address[2 +: WSEL_W] & WMASK;
  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_word = data_q[hit_way][idx][word];
  assign victim   = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
  assign read_hit = (state_q == IDLE) && !cpu.flush && !cpu.write_en && cpu.read_en && hit;

  always_comb begin
    for (int i = 0; i < WORDS_PER_BLOCK; i++)
      blk_in[i] = mem.sram_read_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d      = state_q;
    ready_c      = 1'b0;
    read_data_d  = read_data_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    clear_all    = 1'b0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    fill_we      = 1'b0;
    wr_we        = 1'b0;
    buf_we       = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (cpu.flush) begin
          ready_c = 1'b0;
          state_d = FLUSH;
        end else if (cpu.write_en) begin
          ready_c = 1'b0;
          state_d = MEM_WRITE;
        end else if (cpu.read_en) begin
          if (hit) begin
            lru_we  = 1'b1;
            lru_val = ~hit_way;
            if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
          end else begin
            ready_c = 1'b0;
            if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
            state_d = MEM_READ;
          end
        end
      end
      FLUSH: begin
        ready_c   = 1'b1;
        clear_all = 1'b1;
        state_d   = IDLE;
      end
      MEM_READ: begin
        if (mem.sram_ready) begin
          buf_we  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        fill_we     = 1'b1;
        lru_we      = 1'b1;
        lru_val     = ~victim;
        read_data_d = fill_q[word];
        state_d     = DONE;
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      MEM_WRITE: begin
        if (mem.sram_ready) begin
          ready_c = 1'b1;
          state_d = IDLE;
          if (hit) begin
            wr_we   = 1'b1;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
      read_data_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      read_data_q  <= read_data_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (clear_all) begin
        valid_q[0] <= '0;
        valid_q[1] <= '0;
        lru_q      <= '0;
      end else begin
        if (fill_we) valid_q[victim][idx] <= 1'b1;
        if (lru_we)  lru_q[idx] <= lru_val;
      end
    end
  end

  // Payload arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (buf_we) fill_q <= blk_in;
    if (fill_we) begin
      tag_q[victim][idx] <= tag;
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
        data_q[victim][idx][i] <= fill_q[i];
    end
    if (wr_we) data_q[hit_way][idx][word] <= cpu.write_data;
  end

  assign cpu.ready           = ready_c | ~rst_n;
  assign cpu.read_data       = read_hit ? hit_word : read_data_q;
  assign mem.sram_read_en    = (state_q == MEM_READ);
  assign mem.sram_write_en   = (state_q == MEM_WRITE);
  assign mem.sram_address    = (state_q == MEM_WRITE) ? cpu.address
                             : {cpu.address[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
  assign mem.sram_write_data = cpu.write_data;
  assign hit_count           = hit_count_q;
  assign miss_count          = miss_count_q;
endmodule

// File: tb/tb_cache_controller_2way.sv
// Directed plus random checking of the 2-way cache against a recency-list cache model and a word memory.
module tb_cache_controller_2way;
  localparam int AW = 32, DW = 32, WPB = 2, SETS = 64, CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_cpu_if  #(.ADDR_W(AW), .DATA_W(DW))                        cpu();
  cache_sram_if #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB)) mem();
  logic [CW-1:0] hit_count, miss_count;

  cache_controller_2way #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB), .SETS(SETS), .CNT_W(CW))
    dut (.clk(clk), .rst_n(rst_n), .cpu(cpu), .mem(mem), .hit_count(hit_count), .miss_count(miss_count));

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] res_m [SETS][$];   // resident block addresses per set, LRU first
  int hits_m = 0;
  int misses_m = 0;

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    logic [31:0] w = a & ~32'h3;
    if (mem_m.exists(w)) return mem_m[w];
    return (w * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] blk(logic [31:0] a);
    return a & ~32'h7;
  endfunction

  function automatic int set_of(logic [31:0] a);
    return int'((a >> 3) % SETS);
  endfunction

  function automatic int find(logic [31:0] a);
    int s = set_of(a);
    for (int i = 0; i < res_m[s].size(); i++)
      if (res_m[s][i] == blk(a)) return i;
    return -1;
  endfunction

  task automatic touch(input logic [31:0] a);
    int s = set_of(a);
    int p = find(a);
    if (p >= 0) begin
      res_m[s].delete(p);
      res_m[s].push_back(blk(a));
    end
  endtask

  task automatic insert(input logic [31:0] a);
    int s = set_of(a);
    if (res_m[s].size() == 2) void'(res_m[s].pop_front());
    res_m[s].push_back(blk(a));
  endtask

  task automatic clear_model();
    for (int s = 0; s < SETS; s++) res_m[s].delete();
  endtask

  function automatic logic [CW-1:0] sat(int n);
    return (n >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    chk("hit_count", 64'(hit_count), 64'(sat(hits_m)));
    chk("miss_count", 64'(miss_count), 64'(sat(misses_m)));
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] w;
    logic hit_e;
    int lat;
    w = mem_rd(a);
    hit_e = (find(a) >= 0);
    cpu.read_en = 1'b1;
    cpu.address = a;
    #1;
    if (hit_e) begin
      chk("rd_hit_ready", 64'(cpu.ready), 64'd1);
      chk("rd_hit_data", 64'(cpu.read_data), 64'(w));
      touch(a);
      hits_m++;
      tick();
      cpu.read_en = 1'b0;
    end else begin
      chk("rd_miss_ready", 64'(cpu.ready), 64'd0);
      chk("rd_miss_rden_early", 64'(mem.sram_read_en), 64'd0);
      tick();
      chk("rd_rden", 64'(mem.sram_read_en), 64'd1);
      chk("rd_addr", 64'(mem.sram_address), 64'(blk(a)));
      lat = $urandom_range(0, 2);
      repeat (lat) begin
        tick();
        chk("rd_hold", 64'(mem.sram_read_en), 64'd1);
        chk("rd_wait_ready", 64'(cpu.ready), 64'd0);
      end
      mem.sram_read_data = {mem_rd(blk(a) + 32'd4), mem_rd(blk(a))};
      mem.sram_ready = 1'b1;
      tick();
      mem.sram_ready = 1'b0;
      mem.sram_read_data = {$urandom, $urandom};
      chk("fill_ready", 64'(cpu.ready), 64'd0);
      chk("fill_rden", 64'(mem.sram_read_en), 64'd0);
      tick();
      chk("done_ready", 64'(cpu.ready), 64'd1);
      chk("done_data", 64'(cpu.read_data), 64'(w));
      cpu.read_en = 1'b0;
      tick();
      insert(a);
      misses_m++;
    end
    check_counts();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
    cpu.write_en = 1'b1;
    cpu.address = a;
    cpu.write_data = d;
    #1;
    chk("wr_req_ready", 64'(cpu.ready), 64'd0);
    tick();
    for (int i = 0; i <= lat; i++) begin
      chk("wr_en", 64'(mem.sram_write_en), 64'd1);
      chk("wr_addr", 64'(mem.sram_address), 64'(a));
      chk("wr_data", 64'(mem.sram_write_data), 64'(d));
      if (i < lat) begin
        chk("wr_wait_ready", 64'(cpu.ready), 64'd0);
        tick();
      end
    end
    mem.sram_ready = 1'b1;
    #1;
    chk("wr_done_ready", 64'(cpu.ready), 64'd1);
    tick();
    mem.sram_ready = 1'b0;
    cpu.write_en = 1'b0;
    mem_m[a & ~32'h3] = d;
    touch(a);
    check_counts();
  endtask

  task automatic do_flush(input logic with_read);
    cpu.flush = 1'b1;
    cpu.read_en = with_read;
    cpu.address = 32'h400;
    #1;
    chk("flush_req_ready", 64'(cpu.ready), 64'd0);
    tick();
    chk("flush_ready", 64'(cpu.ready), 64'd1);
    cpu.flush = 1'b0;
    cpu.read_en = 1'b0;
    tick();
    clear_model();
    check_counts();
  endtask

  initial begin
    logic [31:0] a;
    int op;
    cpu.read_en = 1'b0;
    cpu.write_en = 1'b0;
    cpu.flush = 1'b0;
    cpu.address = '0;
    cpu.write_data = '0;
    mem.sram_read_data = '0;
    mem.sram_ready = 1'b0;
    #2;
    chk("rst_ready", 64'(cpu.ready), 64'd1);
    chk("rst_rdata", 64'(cpu.read_data), 64'd0);
    chk("rst_rden", 64'(mem.sram_read_en), 64'd0);
    chk("rst_wren", 64'(mem.sram_write_en), 64'd0);
    check_counts();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    mem_m[32'h400] = 32'hAAAA_AAAA;
    mem_m[32'h404] = 32'hBBBB_BBBB;
    do_read(32'h400);
    do_read(32'h404);

    do_read(32'h600);
    do_read(32'h400);
    do_read(32'h800);
    do_read(32'h400);
    do_read(32'h600);

    do_write(32'h404, 32'h1234_5678, 2);
    do_read(32'h404);
    do_write(32'hC00, 32'hCAFE_0C00, 1);
    do_read(32'hC00);

    do_flush(1'b1);
    do_read(32'h404);

    cpu.read_en = 1'b1;
    cpu.address = 32'hA08;
    tick();
    chk("mid_rden", 64'(mem.sram_read_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rden", 64'(mem.sram_read_en), 64'd0);
    chk("mid_rst_ready", 64'(cpu.ready), 64'd1);
    chk("mid_rst_rdata", 64'(cpu.read_data), 64'd0);
    hits_m = 0;
    misses_m = 0;
    clear_model();
    check_counts();
    cpu.read_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_read(32'hA08);

    do_read(32'h400);
    for (int i = 0; i < 20; i++) do_read(32'h404);

    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 1) << 3) | ($urandom_range(0, 1) << 2);
      op = $urandom_range(0, 99);
      if (op < 70)      do_read(a);
      else if (op < 95) do_write(a, $urandom, $urandom_range(0, 3));
      else              do_flush(1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
